// File: rtl/gpio_fifo_bridge_if.sv
// Pin-level handshake bundle between the GPIO host header and the chip side.
// slave = bridge view, master = host/chip (bench) view.
interface gpio_fifo_bridge_if #(
  parameter int DATA_W = 4
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ack;
  logic [DATA_W-1:0] tx_data;
  logic              tx_req_n;
  logic              tx_ack;

  modport master (
    output rx_valid, rx_data, tx_ack,
    input  rx_ack, tx_data, tx_req_n
  );

  modport slave (
    input  rx_valid, rx_data, tx_ack,
    output rx_ack, tx_data, tx_req_n
  );
endinterface

// File: rtl/gpio_fifo_bridge.sv
// Host 4-phase valid/ack pins -> DEPTH-entry FIFO -> chip active-low req/ack pins.
// All pin inputs are asynchronous and pass through SYNC_STAGES flops.
module gpio_fifo_bridge #(
  parameter int DATA_W       = 4,
  parameter int DEPTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  gpio_fifo_bridge_if.slave      bus,
  input  logic                   i_ovf_clr,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic       {R_IDLE, R_ACK}          rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT}  tx_state_t;

  rx_state_t r_rx_state;
  tx_state_t r_tx_state;

  logic [SYNC_STAGES-1:0]             r_rxv_sync;
  logic [SYNC_STAGES-1:0]             r_txa_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_rxd_sync;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_empty, r_full, r_overflow;
  logic              r_rx_ack, r_tx_req_n;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_rxv_s, w_txa_s;
  logic [DATA_W-1:0] w_rxd_s;
  logic              w_push, w_pop, w_drop;
  logic [CW-1:0]     w_count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxv_sync <= '0;
      r_txa_sync <= '0;
      r_rxd_sync <= '0;
    end else begin
      r_rxv_sync <= {r_rxv_sync[SYNC_STAGES-2:0], bus.rx_valid};
      r_txa_sync <= {r_txa_sync[SYNC_STAGES-2:0], bus.tx_ack};
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], bus.rx_data};
    end
  end

  assign w_rxv_s = r_rxv_sync[SYNC_STAGES-1];
  assign w_txa_s = r_txa_sync[SYNC_STAGES-1];
  assign w_rxd_s = r_rxd_sync[SYNC_STAGES-1];

  // rx_data is held stable by the host for the whole strobe, so it has settled
  // through its synchroniser by the time the equally delayed valid is seen.
  assign w_push = (r_rx_state == R_IDLE) && w_rxv_s && !r_full;
  assign w_drop = DROP_ON_FULL && (r_rx_state == R_IDLE) && w_rxv_s && r_full;
  assign w_pop  = (r_tx_state == T_REQ) && w_txa_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= R_IDLE;
      r_rx_ack   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_rx_state)
        R_IDLE: if (w_push || w_drop) begin
          r_rx_ack   <= 1'b1;
          r_rx_state <= R_ACK;
        end
        R_ACK: if (!w_rxv_s) begin
          r_rx_ack   <= 1'b0;
          r_rx_state <= R_IDLE;
        end
        default: r_rx_state <= R_IDLE;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_tx_req_n <= 1'b1;
      r_tx_data  <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: if (!r_empty) begin
          r_tx_data  <= r_mem[r_rptr];
          r_tx_req_n <= 1'b0;
          r_tx_state <= T_REQ;
        end
        T_REQ: if (w_txa_s) begin
          r_tx_req_n <= 1'b1;
          r_tx_state <= T_WAIT;
        end
        T_WAIT: if (!w_txa_s) r_tx_state <= T_IDLE;
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rxd_s;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign bus.rx_ack   = r_rx_ack;
  assign bus.tx_req_n = r_tx_req_n;
  assign bus.tx_data  = r_tx_data;
  assign o_count      = r_count;
  assign o_empty      = r_empty;
  assign o_full       = r_full;
  assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_gpio_fifo_bridge.sv
// Scoreboard bench: dut0 in backpressure mode, dut1 in drop-on-full mode.
// Expected words are queued at issue time; monitors pop them when tx_req_n falls.
module tb_gpio_fifo_bridge;
  logic clk = 1'b0;
  logic rst;
  logic ovf_clr0, ovf_clr1;
  logic [3:0] count0, count1;
  logic empty0, empty1, full0, full1, ovf0, ovf1;
  logic auto0, auto1, man0, man1, aack0, aack1;
  logic prev0 = 1'b1, prev1 = 1'b1;
  int   n_cmp = 0, n_err = 0;
  logic [3:0] q0[$], q1[$];

  always #5 clk = ~clk;

  gpio_fifo_bridge_if #(.DATA_W(4)) bus0 ();
  gpio_fifo_bridge_if #(.DATA_W(4)) bus1 ();

  assign bus0.tx_ack = auto0 ? aack0 : man0;
  assign bus1.tx_ack = auto1 ? aack1 : man1;

  gpio_fifo_bridge #(.DATA_W(4), .DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .i_ovf_clr(ovf_clr0),
    .o_count(count0), .o_empty(empty0), .o_full(full0), .o_overflow(ovf0)
  );

  gpio_fifo_bridge #(.DATA_W(4), .DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .i_ovf_clr(ovf_clr1),
    .o_count(count1), .o_empty(empty1), .o_full(full1), .o_overflow(ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Chip-side responders: ack after a random 0..4 cycle delay, release when req rises.
  initial begin
    int dly0, dly1;
    aack0 = 1'b0; aack1 = 1'b0; dly0 = 0; dly1 = 0;
    forever begin
      @(negedge clk);
      if (!auto0) begin aack0 = 1'b0; dly0 = 0; end
      else if (!aack0 && !bus0.tx_req_n) begin
        if (dly0 == 0) begin aack0 = 1'b1; dly0 = $urandom_range(0, 4); end
        else dly0--;
      end else if (aack0 && bus0.tx_req_n) aack0 = 1'b0;
      if (!auto1) begin aack1 = 1'b0; dly1 = 0; end
      else if (!aack1 && !bus1.tx_req_n) begin
        if (dly1 == 0) begin aack1 = 1'b1; dly1 = $urandom_range(0, 4); end
        else dly1--;
      end else if (aack1 && bus1.tx_req_n) aack1 = 1'b0;
    end
  end

  // Monitors: every new word offered to the chip is checked against the queue head.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (prev0 && !bus0.tx_req_n) begin
        if (q0.size() == 0) chk("dut0_unexpected_word", int'(bus0.tx_data), -1);
        else begin e = q0.pop_front(); chk("dut0_tx_data", int'(bus0.tx_data), int'(e)); end
      end
      if (prev1 && !bus1.tx_req_n) begin
        if (q1.size() == 0) chk("dut1_unexpected_word", int'(bus1.tx_data), -1);
        else begin e = q1.pop_front(); chk("dut1_tx_data", int'(bus1.tx_data), int'(e)); end
      end
      prev0 = bus0.tx_req_n;
      prev1 = bus1.tx_req_n;
    end
  end

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus0.rx_ack : bus1.rx_ack;
  endfunction

  task automatic set_rx(input int sel, input logic v, input logic [3:0] d);
    if (sel == 0) begin bus0.rx_valid = v; bus0.rx_data = d; end
    else          begin bus1.rx_valid = v; bus1.rx_data = d; end
  endtask

  task automatic wait_ack_low(input int sel);
    int t = 0;
    while (get_ack(sel) !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    chk("rx_ack_fall_in_time", int'(t < 100), 1);
  endtask

  task automatic send(input int sel, input logic [3:0] d, input bit exp_out);
    int t = 0;
    if (exp_out) begin
      if (sel == 0) q0.push_back(d); else q1.push_back(d);
    end
    @(negedge clk);
    set_rx(sel, 1'b1, d);
    while (get_ack(sel) !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("rx_ack_rise_in_time", int'(t < 100), 1);
    set_rx(sel, 1'b0, d);
    wait_ack_low(sel);
  endtask

  task automatic wait_drain(input int sel);
    int t = 0;
    if (sel == 0)
      while (!(empty0 && bus0.tx_req_n && !bus0.tx_ack) && t < 400) begin @(negedge clk); t++; end
    else
      while (!(empty1 && bus1.tx_req_n && !bus1.tx_ack) && t < 400) begin @(negedge clk); t++; end
    chk("drain_in_time", int'(t < 400), 1);
  endtask

  initial begin
    int t;
    rst = 1'b1; ovf_clr0 = 1'b0; ovf_clr1 = 1'b0;
    auto0 = 1'b0; auto1 = 1'b0; man0 = 1'b0; man1 = 1'b0;
    set_rx(0, 1'b0, 4'h0); set_rx(1, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_rx_ack", int'(bus0.rx_ack), 0);
    chk("rst_tx_req_n", int'(bus0.tx_req_n), 1);
    chk("rst_tx_data", int'(bus0.tx_data), 0);
    chk("rst_count", int'(count0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_full", int'(full0), 0);
    chk("rst_overflow", int'(ovf1), 0);
    rst = 1'b0;

    // T1: reset while a word is being requested from the chip
    send(0, 4'h5, 1'b1);
    repeat (2) @(negedge clk);
    chk("t1_req_before_rst", int'(bus0.tx_req_n), 0);
    #2 rst = 1'b1;
    #1;
    chk("t1_tx_req_n", int'(bus0.tx_req_n), 1);
    chk("t1_rx_ack", int'(bus0.rx_ack), 0);
    chk("t1_count", int'(count0), 0);
    chk("t1_empty", int'(empty0), 1);
    @(negedge clk) rst = 1'b0;
    chk("t1_queue_empty", q0.size(), 0);

    // T2: single word with exact pin-to-pin latencies
    @(negedge clk);
    set_rx(0, 1'b1, 4'hA);
    q0.push_back(4'hA);
    @(posedge clk); @(posedge clk); #1;
    chk("t2_rx_ack_early", int'(bus0.rx_ack), 0);
    @(posedge clk); #1;
    chk("t2_rx_ack_3edges", int'(bus0.rx_ack), 1);
    chk("t2_count_1", int'(count0), 1);
    @(posedge clk); #1;
    chk("t2_req_4edges", int'(bus0.tx_req_n), 0);
    chk("t2_tx_data", int'(bus0.tx_data), 10);
    @(negedge clk);
    set_rx(0, 1'b0, 4'hA);
    man0 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("t2_req_held", int'(bus0.tx_req_n), 0);
    @(posedge clk); #1;
    chk("t2_req_release", int'(bus0.tx_req_n), 1);
    chk("t2_count_0", int'(count0), 0);
    chk("t2_tx_data_hold", int'(bus0.tx_data), 10);
    @(negedge clk) man0 = 1'b0;
    repeat (4) @(negedge clk);

    // T3: fill, backpressure on the 9th word, release by one pop
    for (int i = 1; i <= 8; i++) send(0, 4'(i), 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_count_8", int'(count0), 8);
    chk("t3_full", int'(full0), 1);
    q0.push_back(4'h9);
    set_rx(0, 1'b1, 4'h9);
    repeat (10) @(negedge clk);
    chk("t3_no_ack_when_full", int'(bus0.rx_ack), 0);
    man0 = 1'b1;
    t = 0;
    while (bus0.tx_req_n !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    man0 = 1'b0;
    t = 0;
    while (bus0.rx_ack !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("t3_ack_after_pop", int'(bus0.rx_ack), 1);
    chk("t3_count_refill", int'(count0), 8);
    set_rx(0, 1'b0, 4'h9);
    wait_ack_low(0);
    auto0 = 1'b1;
    wait_drain(0);
    chk("t3_no_overflow_bp", int'(ovf0), 0);
    chk("t3_queue_empty", q0.size(), 0);
    auto0 = 1'b0;
    repeat (4) @(negedge clk);

    // T5: push and pop on the same edge with count=3
    send(0, 4'h1, 1'b1); send(0, 4'h2, 1'b1); send(0, 4'h3, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_count_3", int'(count0), 3);
    q0.push_back(4'h4);
    set_rx(0, 1'b1, 4'h4);
    man0 = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("t5_push", int'(bus0.rx_ack), 1);
    chk("t5_pop", int'(bus0.tx_req_n), 1);
    chk("t5_count_kept", int'(count0), 3);
    @(negedge clk);
    man0 = 1'b0;
    set_rx(0, 1'b0, 4'h4);
    wait_ack_low(0);
    auto0 = 1'b1;
    wait_drain(0);
    chk("t5_queue_empty", q0.size(), 0);

    // T6: 20-word stream with random chip ack delays, pointers wrap
    for (int i = 0; i < 20; i++) send(0, 4'(i), 1'b1);
    wait_drain(0);
    chk("t6_queue_empty", q0.size(), 0);
    chk("t6_count_0", int'(count0), 0);

    // T4: drop mode on dut1
    for (int i = 1; i <= 8; i++) send(1, 4'(i), 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_count_8", int'(count1), 8);
    chk("t4_full", int'(full1), 1);
    chk("t4_ovf_before", int'(ovf1), 0);
    send(1, 4'hF, 1'b0);
    chk("t4_ovf_set", int'(ovf1), 1);
    chk("t4_count_after_drop", int'(count1), 8);
    @(negedge clk) ovf_clr1 = 1'b1;
    @(negedge clk) ovf_clr1 = 1'b0;
    chk("t4_ovf_cleared", int'(ovf1), 0);
    @(negedge clk);
    set_rx(1, 1'b1, 4'hE);
    @(posedge clk); @(posedge clk);
    @(negedge clk) ovf_clr1 = 1'b1;
    @(posedge clk); #1;
    chk("t4_drop_acked", int'(bus1.rx_ack), 1);
    chk("t4_set_beats_clr", int'(ovf1), 1);
    @(negedge clk);
    ovf_clr1 = 1'b0;
    set_rx(1, 1'b0, 4'hE);
    @(negedge clk);
    chk("t4_ovf_sticky", int'(ovf1), 1);
    wait_ack_low(1);
    auto1 = 1'b1;
    wait_drain(1);
    chk("t4_queue_empty", q1.size(), 0);
    chk("t4_count_0", int'(count1), 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
